// File: rtl/cs_delay_pkg.sv
// Shared types and default sizing for the chip-select delay-line controller.
package cs_delay_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        FLUSH     = 2'd2,
        APPLY     = 2'd3
    } state_t;

    localparam int DEF_LEN_W   = 4;
    localparam int DEF_MAX_LEN = 15;

endpackage

// File: rtl/btn_debounce.sv
// Sample-and-hold debouncer for one raw push button, advanced by a shared slow tick.
module btn_debounce #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic press
);

    logic [N-1:0] samples;
    logic [N-1:0] samples_next;

    assign samples_next = {samples[N-2:0], raw};

    // A level is accepted only once the whole window agrees; press marks accepted rising levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples <= '0;
            stable  <= 1'b0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (tick) begin
                samples <= samples_next;
                if ((&samples_next) && !stable) begin
                    stable <= 1'b1;
                    press  <= 1'b1;
                end else if (!(|samples_next) && stable) begin
                    stable <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cs_delay_ctrl.sv
// Button-driven length controller; commits a new delay length only after cs has been idle long enough.
module cs_delay_ctrl
    import cs_delay_pkg::*;
#(
    parameter int DIV     = 50_000,
    parameter int N       = 8,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int GUARD   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs,
    input  logic             btn_up_raw,
    input  logic             btn_dn_raw,
    input  logic             btn_lock_raw,
    output logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] len_target,
    output logic             locked,
    output logic             flush,
    output logic             update_done,
    output logic             busy
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDLE_W = $clog2(GUARD + 1);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              up_press;
    logic              dn_press;
    logic              lock_press;
    logic [2:0]        unused_stable;
    logic              locked_next;
    state_t            state;
    state_t            state_next;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_cnt_next;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    btn_debounce #(.N(N)) u_up (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .raw    (btn_up_raw),
        .stable (unused_stable[0]),
        .press  (up_press)
    );

    btn_debounce #(.N(N)) u_dn (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .raw    (btn_dn_raw),
        .stable (unused_stable[1]),
        .press  (dn_press)
    );

    btn_debounce #(.N(N)) u_lock (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .raw    (btn_lock_raw),
        .stable (unused_stable[2]),
        .press  (lock_press)
    );

    // The lock toggle lands first so a simultaneous up/down sees the new lock state.
    assign locked_next = locked ^ lock_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked     <= 1'b0;
            len_target <= '0;
        end else begin
            locked <= locked_next;
            if (!locked_next && (up_press != dn_press)) begin
                if (up_press) begin
                    len_target <= (len_target == LEN_W'(MAX_LEN)) ? '0 : len_target + 1'b1;
                end else begin
                    len_target <= (len_target == '0) ? LEN_W'(MAX_LEN) : len_target - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            flush       <= 1'b0;
            update_done <= 1'b0;
            len         <= '0;
        end else begin
            state       <= state_next;
            idle_cnt    <= idle_cnt_next;
            flush       <= (state == FLUSH);
            update_done <= (state == APPLY);
            if (state == APPLY) begin
                len <= len_target;
            end
        end
    end

    // Once FLUSH is entered the commit is unconditional; the target is sampled as late as APPLY.
    always_comb begin
        state_next    = state;
        idle_cnt_next = idle_cnt;
        unique case (state)
            IDLE: begin
                if (len_target != len) begin
                    state_next    = WAIT_IDLE;
                    idle_cnt_next = '0;
                end
            end
            WAIT_IDLE: begin
                if (len_target == len) begin
                    state_next = IDLE;
                end else if (cs) begin
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt + 1'b1;
                    if (idle_cnt == IDLE_W'(GUARD - 1)) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH:   state_next = APPLY;
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
